// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB/JUMP sequencer for the multi-cycle datapath; ILLEGAL_TRAP_EN makes undefined opcodes halt.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func_code,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       busy,
  output logic       mem_err,
  output logic       illegal
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
                         WB = 3'd4, JUMP = 3'd5, HALT = 3'd6;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b100011, OP_ANDI = 6'b001111,
                         OP_SUBI = 6'b110001, OP_MULI = 6'b111000, OP_ORI = 6'b001110,
                         OP_XORI = 6'b001100, OP_SLTI = 6'b001000, OP_BEQ = 6'b100000,
                         OP_BRG = 6'b100010, OP_BRL = 6'b100101, OP_BNE = 6'b000111,
                         OP_BRZ = 6'b000110, OP_LW = 6'b010001, OP_SW = 6'b011001,
                         OP_JA = 6'b110100, OP_JAL = 6'b111110, FN_JR = 6'b000001;
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  localparam bit TO_EN = MEM_TIMEOUT > 0;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
  localparam logic [2:0] BAD_NEXT = HALT;
`else
  localparam bit TRAP = 1'b0;
  localparam logic [2:0] BAD_NEXT = FETCH;
`endif

  function automatic logic is_imm(input logic [5:0] o);
    return o inside {OP_ADDI, OP_ANDI, OP_SUBI, OP_MULI, OP_ORI, OP_XORI, OP_SLTI};
  endfunction

  function automatic logic is_br(input logic [5:0] o);
    return o inside {OP_BEQ, OP_BRG, OP_BRL, OP_BNE, OP_BRZ};
  endfunction

  function automatic logic is_jump(input logic [5:0] o);
    return o inside {OP_JA, OP_JAL};
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return o == OP_R || is_imm(o) || is_br(o) || is_jump(o) || o == OP_LW || o == OP_SW;
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI: return 4'b0011;
      OP_SUBI: return 4'b0001;
      OP_MULI: return 4'b0100;
      OP_ORI:  return 4'b0101;
      OP_XORI: return 4'b0110;
      OP_SLTI: return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] br_alu(input logic [5:0] o);
    case (o)
      OP_BRG:  return 4'b1000;
      OP_BRL:  return 4'b1001;
      OP_BNE:  return 4'b1010;
      OP_BRZ:  return 4'b1011;
      default: return 4'b0001;
    endcase
  endfunction

  logic [2:0] state, state_n;
  logic [5:0] op_q, func_q;
  logic [CW-1:0] cnt;
  logic run, wait_st, timeout, ls, to_wb;
  logic unused_ok;

  assign unused_ok = alu_zero;
  assign wait_st = (state == FETCH && run) || state == MEM;
  assign timeout = TO_EN && wait_st && !mem_ready && cnt == LAST;
  assign ls = op_q == OP_LW || op_q == OP_SW;
  assign to_wb = (op_q == OP_R && func_q != FN_JR) || is_imm(op_q);

  // next-state selection; only FETCH/MEM look at mem_ready, only DECODE looks at op
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = !run ? FETCH : mem_ready ? DECODE : timeout ? HALT : FETCH;
      DECODE:  state_n = !is_legal(op) ? BAD_NEXT : is_jump(op) ? JUMP : EXEC;
      EXEC:    state_n = ls ? MEM : to_wb ? WB : FETCH;
      MEM:     state_n = mem_ready ? (op_q == OP_SW ? FETCH : WB) : timeout ? HALT : MEM;
      WB:      state_n = FETCH;
      JUMP:    state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // state, idle-after-reset flag, wait counter, latched instruction fields and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      run     <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
      func_q  <= '0;
      mem_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      run     <= 1'b1;
      cnt     <= (state_n != state || !wait_st) ? '0 : cnt + 1'b1;
      mem_err <= mem_err | timeout;
      illegal <= (TRAP & illegal) | (state == DECODE && !is_legal(op));
      if (state == DECODE) begin
        op_q   <= op;
        func_q <= func_code;
      end
    end
  end

  // Moore control decode; ir_write/pc_write in FETCH are the only mem_ready-qualified strobes
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    busy          = !(state == FETCH && !run);
    case (state)
      FETCH: if (run) begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      EXEC: begin
        alu_src_a = 1'b1;
        if (op_q == OP_R) begin
          alu_op   = 4'b0010;
          pc_write = func_q == FN_JR;
          pc_src   = func_q == FN_JR ? 2'b11 : 2'b00;
        end else if (is_imm(op_q)) begin
          alu_src_b = 2'b10;
          alu_op    = imm_alu(op_q);
        end else if (is_br(op_q)) begin
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          alu_op        = br_alu(op_q);
        end else if (ls) begin
          alu_src_b = 2'b10;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_write = op_q == OP_SW;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = op_q == OP_R ? 2'b01 : 2'b00;
        mem_to_reg = op_q == OP_LW ? 2'b01 : 2'b00;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        if (op_q == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          alu_op     = 4'b1100;
        end
      end
      default: ;
    endcase
  end
endmodule
